// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the SRAM slave state enumeration and a byte-lane helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Little-endian lanes [off, off + 2**size) of an 8-lane bus; callers slice to their width.
    function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [2:0] size);
        logic [7:0] m;
        for (int b = 0; b < 8; b++) begin
            m[b] = (4'(b) >= {1'b0, off}) && (4'(b) < ({1'b0, off} + (4'd1 << size)));
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-enabled SRAM array: one synchronous write port, one asynchronous read port.
module ahb_sram_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   widx_i,
    input  logic [DATA_W/8-1:0]        be_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   ridx_i,
    output logic [DATA_W-1:0]          rdata_o
);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // Word i powers up holding i so simulation starts from a known image.
    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(i);
        end
        return m;
    endfunction

    mem_t mem_q = mem_init();

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be_i[b]) begin
                    mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined single beats, programmable wait states, two-cycle ERROR
// for out-of-range, oversized or misaligned accesses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [1:0]        htrans,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int         BYTES    = DATA_W / 8;
    localparam int         OFF_W    = $clog2(BYTES);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         AL_W     = OFF_W + IDX_W;
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [AL_W-1:0]     addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [2:0]          size_q, size_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q, hresp_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;

    logic                accept, illegal;
    logic                range_bad, size_bad, align_bad;
    logic [7:0]          size_mask, lane_m;
    logic                mem_we;
    logic [BYTES-1:0]    mem_be;
    logic [IDX_W-1:0]    widx, ridx;
    logic [DATA_W-1:0]   mem_rdata, rd_word;
    logic                unused_inputs;

    // hready is low throughout WAIT and ERR1, so those states never see an accept.
    assign accept = hsel && hready
                 && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                 && (state_q inside {ST_IDLE, ST_DATA, ST_ERR2});

    assign size_mask = 8'((9'd1 << hsize) - 9'd1);
    assign range_bad = (haddr >> OFF_W) >= ADDR_W'(DEPTH);
    assign size_bad  = hsize > MAX_SIZE;
    assign align_bad = (8'(haddr[OFF_W-1:0]) & size_mask) != 8'd0;
    assign illegal   = range_bad || size_bad || align_bad;

    assign lane_m = lane_mask(3'(addr_q[OFF_W-1:0]), size_q);
    assign mem_be = lane_m[BYTES-1:0];
    assign mem_we = (state_q == ST_DATA) && wr_q;
    assign widx   = addr_q[OFF_W +: IDX_W];
    assign ridx   = accept ? haddr[OFF_W +: IDX_W] : addr_q[OFF_W +: IDX_W];

    ahb_sram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (hclk),
        .we_i    (mem_we),
        .widx_i  (widx),
        .be_i    (mem_be),
        .wdata_i (hwdata),
        .ridx_i  (ridx),
        .rdata_o (mem_rdata)
    );

    // A read pipelined right behind a write to the same word sees the bytes committing now.
    always_comb begin
        rd_word = mem_rdata;
        for (int b = 0; b < BYTES; b++) begin
            if (mem_we && (widx == ridx) && mem_be[b]) begin
                rd_word[b*8 +: 8] = hwdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            addr_d = haddr[AL_W-1:0];
            wr_d   = hwrite;
            size_d = hsize;
            if (illegal) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 3'(WAIT_STATES);
            end else begin
                state_d = ST_DATA;
            end
        end

        hreadyout_d = !(state_d inside {ST_WAIT, ST_ERR1});
        hresp_d     = (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
        hrdata_d    = (state_d == ST_DATA && !wr_d) ? rd_word : hrdata_q;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            size_q      <= HSIZE_BYTE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;

    // Burst type, protection and lock have no effect on a single-port SRAM.
    assign unused_inputs = ^{hburst, hprot, hmastlock, lane_m};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance, driven by a pipelined
// master task and checked against a byte-level memory model.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int DEPTH = 32;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel_b;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    int          tgt;

    logic        ro0, ro1, rs0, rs1;
    logic [31:0] rd0, rd1;

    always #5 hclk = ~hclk;

    ahb_sram_slave u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b && tgt == 0), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
        .hmastlock(hmastlock), .hready(ro0), .hwdata(hwdata),
        .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
    );

    ahb_sram_slave #(.WAIT_STATES(2)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b && tgt == 1), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
        .hmastlock(hmastlock), .hready(ro1), .hwdata(hwdata),
        .hreadyout(ro1), .hresp(rs1), .hrdata(rd1)
    );

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];
    int          ws [2] = '{0, 2};
    logic [31:0] obs_rd;
    int          checks = 0;
    int          errors = 0;

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
        return (a / 4 < DEPTH) && (sz <= 3'd2) && (a % (32'd1 << sz) == 0);
    endfunction

    task automatic push(input bit sel, input logic [1:0] tr, input bit wr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        beat_t b;
        b.sel = sel; b.trans = tr; b.wr = wr; b.addr = a; b.size = sz; b.data = d;
        q.push_back(b);
    endtask

    task automatic drive_idle();
        hsel_b = 1'b0; htrans = HTRANS_IDLE; haddr = $urandom; hwrite = 1'b0;
        hsize = 3'($urandom); hwdata = $urandom;
    endtask

    // Master: beat i sits on the address bus until the slave is ready, overlapping the
    // data phase of the previously accepted beat. Entered and left at posedge + 1.
    task automatic run_beats(input string tag);
        beat_t p;
        bit    have_p = 0, rdy, rs, resp_bad = 0, xfer, legal, exp_resp;
        int    i = 0, waits = 0, exp_waits, cyc = 0;
        logic [31:0] hrd, exp_rd;
        int    limit = q.size() * 12 + 20;
        while (i < q.size() || have_p) begin
            if (i < q.size()) begin
                hsel_b = q[i].sel; htrans = q[i].trans; haddr = q[i].addr;
                hwrite = q[i].wr; hsize = q[i].size;
            end else begin
                drive_idle();
            end
            hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
            hwdata = (have_p && p.wr) ? p.data : $urandom;
            rdy = (tgt == 0) ? ro0 : ro1;
            rs  = (tgt == 0) ? rs0 : rs1;
            hrd = (tgt == 0) ? rd0 : rd1;
            if (have_p) begin
                xfer     = p.sel && p.trans[1];
                legal    = xfer && is_legal(p.addr, p.size);
                exp_resp = xfer && !legal;
                if (rs !== exp_resp) resp_bad = 1;
                if (!rdy) begin
                    waits++;
                end else begin
                    exp_waits = !xfer ? 0 : (legal ? ws[tgt] : 1);
                    checks++;
                    if (waits != exp_waits) begin
                        errors++;
                        $display("FAIL %s waits @%h: got %0d expected %0d", tag, p.addr, waits, exp_waits);
                    end
                    checks++;
                    if (resp_bad) begin
                        errors++;
                        $display("FAIL %s hresp @%h: last %0b expected %0b", tag, p.addr, rs, exp_resp);
                    end
                    if (legal && !p.wr) last_rd[tgt] = mdl[tgt][p.addr / 4];
                    exp_rd = last_rd[tgt];
                    obs_rd = hrd;
                    checks++;
                    if (hrd !== exp_rd) begin
                        errors++;
                        $display("FAIL %s hrdata @%h: got %h expected %h", tag, p.addr, hrd, exp_rd);
                    end
                    if (legal && p.wr) begin
                        for (int k = 0; k < (1 << p.size); k++) begin
                            int lane;
                            lane = int'(p.addr % 4) + k;
                            mdl[tgt][p.addr / 4][lane*8 +: 8] = p.data[lane*8 +: 8];
                        end
                    end
                    have_p = 0;
                end
            end
            @(posedge hclk); #1;
            if (rdy && i < q.size()) begin
                p = q[i]; have_p = 1; waits = 0; resp_bad = 0; i++;
            end
            cyc++;
            if (cyc > limit) begin
                checks++; errors++;
                $display("FAIL %s timeout: got %0d cycles expected at most %0d", tag, cyc, limit);
                break;
            end
        end
        drive_idle();
        q.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; tgt = 0;
        @(posedge hclk); #1;
        checks += 6;
        if (ro0 !== 1'b1 || ro1 !== 1'b1) begin errors++; $display("FAIL reset hreadyout: got %b%b expected 11", ro1, ro0); end
        else checks--;
        if (rs0 !== 1'b0 || rs1 !== 1'b0) begin errors++; $display("FAIL reset hresp: got %b%b expected 00", rs1, rs0); end
        else checks--;
        if (rd0 !== 32'h0) begin errors++; $display("FAIL reset hrdata0: got %h expected 0", rd0); end
        if (rd1 !== 32'h0) begin errors++; $display("FAIL reset hrdata1: got %h expected 0", rd1); end
        checks -= 2;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        push(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 0);
        run_beats("first_after_reset");
    endtask

    task automatic test_word_rw();
        tgt = 0;
        push(1, HTRANS_NONSEQ, 1, 32'h08, HSIZE_WORD, 32'hDEADBEEF);
        push(1, HTRANS_NONSEQ, 0, 32'h08, HSIZE_WORD, 0);
        run_beats("word_rw");
        checks++;
        if (obs_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rw value: got %h expected deadbeef", obs_rd); end
    endtask

    task automatic test_byte_write();
        tgt = 0;
        push(1, HTRANS_NONSEQ, 1, 32'h05, HSIZE_BYTE, 32'h0000AB00);
        push(1, HTRANS_NONSEQ, 0, 32'h04, HSIZE_WORD, 0);
        run_beats("byte_write");
        checks++;
        if (obs_rd !== 32'h0000AB01) begin errors++; $display("FAIL byte_write value: got %h expected 0000ab01", obs_rd); end
    endtask

    task automatic test_wait_states();
        tgt = 1;
        push(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 0);
        run_beats("wait_states");
        checks++;
        if (obs_rd !== 32'h3) begin errors++; $display("FAIL wait_states value: got %h expected 00000003", obs_rd); end
        push(1, HTRANS_NONSEQ, 1, 32'h0E, HSIZE_HALF, 32'h5A5A0000);
        push(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 0);
        run_beats("wait_states_rw");
    endtask

    task automatic test_errors();
        tgt = 0;
        push(1, HTRANS_NONSEQ, 0, 32'h80, HSIZE_WORD, 0);
        push(1, HTRANS_NONSEQ, 1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF);
        push(1, HTRANS_NONSEQ, 1, 32'h00, HSIZE_DWORD, 32'hFFFFFFFF);
        push(1, HTRANS_NONSEQ, 0, 32'h00, HSIZE_WORD, 0);
        run_beats("errors");
        checks++;
        if (obs_rd !== 32'h0) begin errors++; $display("FAIL errors mem_unchanged: got %h expected 0", obs_rd); end
        tgt = 1;
        push(1, HTRANS_NONSEQ, 0, 32'h84, HSIZE_WORD, 0);
        push(1, HTRANS_NONSEQ, 1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF);
        push(1, HTRANS_NONSEQ, 0, 32'h00, HSIZE_WORD, 0);
        run_beats("errors_ws");
    endtask

    task automatic test_burst();
        tgt = 0;
        for (int k = 0; k < 4; k++) begin
            push(1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1, 32'h10 + 32'(4*k), HSIZE_WORD, $urandom);
        end
        push(1, HTRANS_BUSY, 1, 32'h20, HSIZE_WORD, 0);
        for (int k = 0; k < 4; k++) begin
            push(1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 0, 32'h10 + 32'(4*k), HSIZE_WORD, 0);
        end
        run_beats("burst");
    endtask

    task automatic test_reset_abort();
        tgt = 1;
        hsel_b = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = 32'h12345678;
        checks++;
        if (ro1 !== 1'b0) begin errors++; $display("FAIL abort in_wait: got hreadyout %b expected 0", ro1); end
        hresetn = 1'b0;
        #1;
        checks++;
        if (ro1 !== 1'b1 || rs1 !== 1'b0 || rd1 !== 32'h0)
            begin errors++; $display("FAIL abort outputs: got %b %b %h expected 1 0 0", ro1, rs1, rd1); end
        checks++;
        if (ro0 !== 1'b1 || rs0 !== 1'b0 || rd0 !== 32'h0)
            begin errors++; $display("FAIL abort outputs0: got %b %b %h expected 1 0 0", ro0, rs0, rd0); end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        push(1, HTRANS_NONSEQ, 0, 32'h20, HSIZE_WORD, 0);
        run_beats("abort_read");
        checks++;
        if (obs_rd !== 32'h8) begin errors++; $display("FAIL abort old_value: got %h expected 00000008", obs_rd); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 2; t++) begin
            tgt = t;
            for (int n = 0; n < 80; n++) begin
                logic [2:0]  sz;
                logic [31:0] a;
                logic [1:0]  tr;
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                a  = $urandom_range(0, 'h9F);
                if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                tr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
                push($urandom_range(0, 9) != 0, tr, 1'($urandom), a, sz, $urandom);
            end
            run_beats(t == 0 ? "random0" : "random1");
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'(i);
        end
        test_reset();
        test_word_rw();
        test_byte_write();
        test_wait_states();
        test_errors();
        test_burst();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
